irq_pending_latch: RTL and testbench

//  Upstream stage of the 8-to-3 priority encoder. Synchronises 8 raw request

---
 rtl/irq_pkg.sv | 11 +
 rtl/sync_rise.sv | 27 ++
 rtl/irq_pending_latch.sv | 67 ++++++
 tb/tb_irq_pending_latch.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants for the interrupt request front end and the downstream
// 8-to-3 priority encoder.
package irq_pkg;

    localparam int unsigned N_IRQ = 8;
    localparam int unsigned IRQ_W = 3;

    localparam logic [N_IRQ-1:0] MASK_ALL  = 8'hFF;
    localparam logic [N_IRQ-1:0] MASK_NONE = 8'h00;

endpackage

// File: rtl/sync_rise.sv
// Single-line synchroniser with a history flop; pulses rise for one cycle on
// each low->high transition seen at the synchroniser output.
module sync_rise #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/irq_pending_latch.sv
// Turns raw request edges into sticky pending bits, tracks overflow and masks
// the result into the priority encoder's input vector.
module irq_pending_latch
    import irq_pkg::*;
#(
    parameter int unsigned   N           = N_IRQ,
    parameter int unsigned   SYNC_STAGES = 2,
    parameter logic [N-1:0]  MASK_RST    = MASK_ALL
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] irq_in,
    input  logic         mask_we,
    input  logic [N-1:0] mask_wdata,
    input  logic         ack_valid,
    input  logic [N-1:0] ack_vec,
    input  logic         ovf_clr,
    output logic [N-1:0] pend_vec,
    output logic         irq_any,
    output logic [N-1:0] mask_q,
    output logic [N-1:0] ovf_vec
);

    logic [N-1:0] rise;
    logic [N-1:0] ack_clr;
    logic [N-1:0] pend_q, pend_d;
    logic [N-1:0] ovf_q, ovf_d;
    logic [N-1:0] mask_d;

    for (genvar i = 0; i < N; i++) begin : g_sync
        sync_rise #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync_rise (
            .clk  (clk),
            .rst_n(rst_n),
            .d    (irq_in[i]),
            .rise (rise[i])
        );
    end

    always_comb begin
        ack_clr = ack_valid ? ack_vec : '0;
        // A set wins over a same-cycle ack on the same bit.
        pend_d  = (pend_q & ~ack_clr) | rise;
        // A fresh overflow wins over ovf_clr; a set coincident with an ack is
        // a normal re-arm, not an overflow.
        ovf_d   = (ovf_clr ? '0 : ovf_q) | (rise & pend_q & ~ack_clr);
        mask_d  = mask_we ? mask_wdata : mask_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
            ovf_q  <= '0;
            mask_q <= MASK_RST;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            mask_q <= mask_d;
        end
    end

    assign pend_vec = pend_q & mask_q;
    assign irq_any  = |pend_vec;
    assign ovf_vec  = ovf_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Self-checking bench for irq_pending_latch: directed scenarios with literal
// expectations plus randomized traffic against a sample-history model.
module tb_irq_pending_latch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq_in;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       ack_valid;
    logic [7:0] ack_vec;
    logic       ovf_clr;
    logic [7:0] pend_vec;
    logic       irq_any;
    logic [7:0] mask_q;
    logic [7:0] ovf_vec;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    irq_pending_latch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (irq_in),
        .mask_we   (mask_we),
        .mask_wdata(mask_wdata),
        .ack_valid (ack_valid),
        .ack_vec   (ack_vec),
        .ovf_clr   (ovf_clr),
        .pend_vec  (pend_vec),
        .irq_any   (irq_any),
        .mask_q    (mask_q),
        .ovf_vec   (ovf_vec)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the pending logic sees an edge on a line when the input sampled
    // two clock edges ago was high and the one three edges ago was low.
    // Samples taken at reset edges count as low.
    logic [7:0] smp [3];
    logic [7:0] m_pend, m_ovf, m_mask;
    bit         model_valid = 1'b0;

    always @(posedge clk) begin
        logic [7:0] rise, acked, np, no;
        if (!rst_n) begin
            m_pend = 8'h00;
            m_ovf  = 8'h00;
            m_mask = 8'hFF;
            for (int k = 0; k < 3; k++) smp[k] = 8'h00;
            model_valid = 1'b1;
        end else if (model_valid) begin
            rise  = smp[1] & ~smp[2];
            acked = ack_valid ? ack_vec : 8'h00;
            np = m_pend;
            no = ovf_clr ? 8'h00 : m_ovf;
            for (int i = 0; i < 8; i++) begin
                if (rise[i]) begin
                    np[i] = 1'b1;
                    if (m_pend[i] && !acked[i]) no[i] = 1'b1;
                end else if (acked[i]) begin
                    np[i] = 1'b0;
                end
            end
            m_pend = np;
            m_ovf  = no;
            if (mask_we) m_mask = mask_wdata;
            smp[2] = smp[1];
            smp[1] = smp[0];
            smp[0] = irq_in;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("model_pend_vec", pend_vec, m_pend & m_mask);
            chk("model_irq_any", {7'd0, irq_any}, {7'd0, |(m_pend & m_mask)});
            chk("model_mask_q", mask_q, m_mask);
            chk("model_ovf_vec", ovf_vec, m_ovf);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_once(input logic [7:0] v);
        ack_valid = 1'b1;
        ack_vec   = v;
        step(1);
        ack_valid = 1'b0;
        ack_vec   = 8'h00;
    endtask

    task automatic write_mask(input logic [7:0] v);
        mask_we    = 1'b1;
        mask_wdata = v;
        step(1);
        mask_we    = 1'b0;
    endtask

    // Return all lines low long enough to flush the synchronisers, then clear.
    task automatic quiesce();
        irq_in = 8'h00;
        step(4);
        ack_once(8'hFF);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        irq_in     = 8'hFF;
        mask_we    = 1'b0;
        mask_wdata = 8'h00;
        ack_valid  = 1'b0;
        ack_vec    = 8'h00;
        ovf_clr    = 1'b0;

        // 1: reset with all lines high, then one event per line.
        step(2);
        chk("rst_pend_vec", pend_vec, 8'h00);
        chk("rst_ovf_vec", ovf_vec, 8'h00);
        chk("rst_mask_q", mask_q, 8'hFF);
        rst_n = 1'b1;
        step(2);
        chk("rst_pend_not_yet", pend_vec, 8'h00);
        step(1);
        chk("rst_release_events", pend_vec, 8'hFF);
        quiesce();

        // 2: latency and short pulse.
        irq_in = 8'h20;
        step(2);
        chk("lat_edge2", pend_vec, 8'h00);
        step(1);
        chk("lat_edge3", pend_vec, 8'h20);
        chk("lat_irq_any", {7'd0, irq_any}, 8'h01);
        irq_in = 8'h00;
        step(3);
        ack_once(8'h20);
        irq_in = 8'h01;
        step(1);
        irq_in = 8'h00;
        step(4);
        chk("pulse_no_x", {7'd0, $isunknown(pend_vec)}, 8'h00);
        quiesce();

        // 3: set/ack collision on line 7.
        irq_in = 8'h80;
        step(3);
        irq_in = 8'h00;
        step(1);
        irq_in = 8'h80;
        step(2);
        ack_once(8'h80);
        chk("coll_pend", pend_vec, 8'h80);
        chk("coll_ovf", ovf_vec, 8'h00);
        ack_once(8'h80);
        chk("coll_ack_alone", pend_vec, 8'h00);
        quiesce();

        // 4: overflow and ovf_clr priority.
        irq_in = 8'h04;
        step(3);
        irq_in = 8'h00;
        step(1);
        irq_in = 8'h04;
        step(3);
        chk("ovf_set", ovf_vec, 8'h04);
        irq_in = 8'h00;
        step(1);
        irq_in = 8'h04;
        step(2);
        ovf_clr = 1'b1;
        step(1);
        chk("ovf_clr_loses", ovf_vec, 8'h04);
        step(1);
        ovf_clr = 1'b0;
        chk("ovf_clr_alone", ovf_vec, 8'h00);
        quiesce();

        // 5: masking.
        write_mask(8'h0F);
        chk("mask_written", mask_q, 8'h0F);
        irq_in = 8'h42;
        step(3);
        chk("mask_hidden", pend_vec, 8'h02);
        write_mask(8'hFF);
        chk("mask_unhide", pend_vec, 8'h42);
        ack_once(8'h40);
        chk("mask_ack40", pend_vec, 8'h02);
        quiesce();

        // 6: reset mid-operation with an edge in flight on line 0.
        irq_in = 8'h3C;
        step(3);
        irq_in = 8'h00;
        write_mask(8'hFE);
        chk("mid_pend", pend_vec, 8'h3C);
        irq_in = 8'h01;
        step(1);
        rst_n  = 1'b0;
        irq_in = 8'h00;
        step(1);
        rst_n = 1'b1;
        chk("mid_rst_pend", pend_vec, 8'h00);
        chk("mid_rst_ovf", ovf_vec, 8'h00);
        chk("mid_rst_mask", mask_q, 8'hFF);
        step(4);
        chk("mid_rst_lost", pend_vec, 8'h00);

        // Randomized traffic, checked every cycle by the model compare.
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] flip;
            flip = 8'h00;
            for (int b = 0; b < 8; b++) if ($urandom_range(3) == 0) flip[b] = 1'b1;
            irq_in     = irq_in ^ flip;
            ack_valid  = ($urandom_range(2) == 0);
            ack_vec    = ($urandom_range(1) == 0) ? (8'h01 << $urandom_range(7))
                                                  : 8'($urandom);
            mask_we    = ($urandom_range(15) == 0);
            mask_wdata = 8'($urandom);
            ovf_clr    = ($urandom_range(20) == 0);
            rst_n      = ($urandom_range(250) != 0);
            step(1);
        end
        rst_n = 1'b1;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
